// File: rtl/br_pkg.sv
// Shared definitions for the branch splitter: packet field widths, packed
// packet layout (field offsets), FIFO sizing, and pack/route helpers.
// Packet layout, MSB to LSB: lr | node | gen | opr | uni_opr | mem_wen.
package br_pkg;

  localparam int LR_W   = 1;
  localparam int NODE_W = 16;
  localparam int GEN_W  = 12;
  localparam int OPR_W  = 32;
  localparam int UNI_W  = 1;
  localparam int WEN_W  = 2;

  localparam int PKT_W      = 64;
  localparam int FIFO_DEPTH = 2;
  localparam int PTR_W      = 1;
  localparam int OCC_W      = 2;

  // Field offsets inside the 64-bit packet word.
  localparam int WEN_LSB  = 0;
  localparam int UNI_LSB  = WEN_LSB + WEN_W;    // 2
  localparam int OPR_LSB  = UNI_LSB + UNI_W;    // 3
  localparam int GEN_LSB  = OPR_LSB + OPR_W;    // 35
  localparam int NODE_LSB = GEN_LSB + GEN_W;    // 47
  localparam int LR_LSB   = NODE_LSB + NODE_W;  // 63

  typedef logic [PKT_W-1:0] pkt_t;

  function automatic pkt_t br_pack(input logic              lr,
                                   input logic [NODE_W-1:0] node,
                                   input logic [GEN_W-1:0]  gen,
                                   input logic [OPR_W-1:0]  opr,
                                   input logic              uni,
                                   input logic [WEN_W-1:0]  wen);
    pkt_t p;
    p = '0;
    p[LR_LSB   +: LR_W]   = lr;
    p[NODE_LSB +: NODE_W] = node;
    p[GEN_LSB  +: GEN_W]  = gen;
    p[OPR_LSB  +: OPR_W]  = opr;
    p[UNI_LSB  +: UNI_W]  = uni;
    p[WEN_LSB  +: WEN_W]  = wen;
    return p;
  endfunction

  // Memory writes always leave via the ICN, as does any packet whose
  // node number names a different processing element.
  function automatic logic br_route_icn(input logic [3:0]        pe_id,
                                        input logic [NODE_W-1:0] node,
                                        input logic [WEN_W-1:0]  wen);
    return (wen != '0) || (node[NODE_W-1 -: 4] != pe_id);
  endfunction

endpackage

// File: rtl/br_fifo2.sv
// Two-entry packet FIFO with registered occupancy and full/empty flags.
// Latency: a word written at edge N is at the head after edge N.
// Backpressure: writes refused while full (even with a same-cycle read).
// Ports: clk, rst | i_wr_vld, i_wr_dat, o_full | i_rd_rdy, o_rd_dat, o_empty
module br_fifo2
  import br_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_vld,
  input  logic [PKT_W-1:0] i_wr_dat,
  output logic             o_full,
  input  logic             i_rd_rdy,
  output logic [PKT_W-1:0] o_rd_dat,
  output logic             o_empty
);

  logic [PKT_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [OCC_W-1:0] r_occ;

  logic w_wr_en;
  logic w_rd_en;

  // Flags decode registered occupancy only, so the upstream ack never
  // depends on a downstream ack in the same cycle.
  assign o_full   = (r_occ == OCC_W'(FIFO_DEPTH));
  assign o_empty  = (r_occ == '0);
  assign w_wr_en  = i_wr_vld & ~o_full;
  assign w_rd_en  = i_rd_rdy & ~o_empty;
  assign o_rd_dat = r_mem[r_rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
    end else begin
      if (w_wr_en) begin
        r_mem[r_wptr] <= i_wr_dat;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_rd_en) r_rptr <= r_rptr + 1'b1;
      case ({w_wr_en, w_rd_en})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule

// File: rtl/br_split.sv
// Routes each incoming packet to the local switch or ICN path, each behind its own 2-entry FIFO.
// Latency: 1 cycle from upstream accept to downstream send.
// Backpressure: upstream ack = not-full of the FIFO the current packet routes to.
// Ports: clk, rst | upstream fields *_i_brs, nInterC_S_i_brs, nInterC_A_o_brs
//        | switch *_o_brs_sw + S/A | ICN *_o_brs_icn + S/A
// Option: BR_SPLIT_STAT_EN adds cnt_sw_o_brs / cnt_icn_o_brs delivery counters.
module br_split
  import br_pkg::*;
#(
  parameter logic [3:0] PE_ID = 4'h0
) (
  input  logic              clk,
  input  logic              rst,
`ifdef BR_SPLIT_STAT_EN
  output logic [15:0]       cnt_sw_o_brs,
  output logic [15:0]       cnt_icn_o_brs,
`endif
  input  logic              lr_i_brs,
  input  logic [NODE_W-1:0] node_i_brs,
  input  logic [GEN_W-1:0]  gen_i_brs,
  input  logic [OPR_W-1:0]  opr_i_brs,
  input  logic              uni_opr_i_brs,
  input  logic [WEN_W-1:0]  mem_wen_i_brs,
  input  logic              nInterC_S_i_brs,
  output logic              nInterC_A_o_brs,
  output logic              lr_o_brs_sw,
  output logic [NODE_W-1:0] node_o_brs_sw,
  output logic [GEN_W-1:0]  gen_o_brs_sw,
  output logic [OPR_W-1:0]  opr_o_brs_sw,
  output logic              uni_opr_o_brs_sw,
  output logic [WEN_W-1:0]  mem_wen_o_brs_sw,
  output logic              nInterC_S_o_brs_sw,
  input  logic              nInterC_A_i_brs_sw,
  output logic              lr_o_brs_icn,
  output logic [NODE_W-1:0] node_o_brs_icn,
  output logic [GEN_W-1:0]  gen_o_brs_icn,
  output logic [OPR_W-1:0]  opr_o_brs_icn,
  output logic              uni_opr_o_brs_icn,
  output logic [WEN_W-1:0]  mem_wen_o_brs_icn,
  output logic              nInterC_S_o_brs_icn,
  input  logic              nInterC_A_i_brs_icn
);

  logic       w_route_icn;
  logic       w_accept;
  logic       w_sw_full, w_sw_empty, w_icn_full, w_icn_empty;
  pkt_t       w_pkt_in, w_sw_dat, w_icn_dat;

  assign w_pkt_in    = br_pack(lr_i_brs, node_i_brs, gen_i_brs, opr_i_brs,
                               uni_opr_i_brs, mem_wen_i_brs);
  assign w_route_icn = br_route_icn(PE_ID, node_i_brs, mem_wen_i_brs);

  // Held low during reset: the FIFOs read empty then, which would
  // otherwise advertise space.
  assign nInterC_A_o_brs = ~rst & (w_route_icn ? ~w_icn_full : ~w_sw_full);
  assign w_accept        = nInterC_S_i_brs & nInterC_A_o_brs;

  br_fifo2 u_fifo_sw (
    .clk      (clk),
    .rst      (rst),
    .i_wr_vld (w_accept & ~w_route_icn),
    .i_wr_dat (w_pkt_in),
    .o_full   (w_sw_full),
    .i_rd_rdy (nInterC_A_i_brs_sw),
    .o_rd_dat (w_sw_dat),
    .o_empty  (w_sw_empty)
  );

  br_fifo2 u_fifo_icn (
    .clk      (clk),
    .rst      (rst),
    .i_wr_vld (w_accept & w_route_icn),
    .i_wr_dat (w_pkt_in),
    .o_full   (w_icn_full),
    .i_rd_rdy (nInterC_A_i_brs_icn),
    .o_rd_dat (w_icn_dat),
    .o_empty  (w_icn_empty)
  );

  assign nInterC_S_o_brs_sw  = ~w_sw_empty;
  assign nInterC_S_o_brs_icn = ~w_icn_empty;

  assign lr_o_brs_sw       = w_sw_dat[LR_LSB   +: LR_W];
  assign node_o_brs_sw     = w_sw_dat[NODE_LSB +: NODE_W];
  assign gen_o_brs_sw      = w_sw_dat[GEN_LSB  +: GEN_W];
  assign opr_o_brs_sw      = w_sw_dat[OPR_LSB  +: OPR_W];
  assign uni_opr_o_brs_sw  = w_sw_dat[UNI_LSB  +: UNI_W];
  assign mem_wen_o_brs_sw  = w_sw_dat[WEN_LSB  +: WEN_W];

  assign lr_o_brs_icn      = w_icn_dat[LR_LSB   +: LR_W];
  assign node_o_brs_icn    = w_icn_dat[NODE_LSB +: NODE_W];
  assign gen_o_brs_icn     = w_icn_dat[GEN_LSB  +: GEN_W];
  assign opr_o_brs_icn     = w_icn_dat[OPR_LSB  +: OPR_W];
  assign uni_opr_o_brs_icn = w_icn_dat[UNI_LSB  +: UNI_W];
  assign mem_wen_o_brs_icn = w_icn_dat[WEN_LSB  +: WEN_W];

`ifdef BR_SPLIT_STAT_EN
  logic [15:0] r_cnt_sw, r_cnt_icn;

  // Counts completed downstream handshakes; wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt_sw  <= '0;
      r_cnt_icn <= '0;
    end else begin
      if (nInterC_S_o_brs_sw & nInterC_A_i_brs_sw)   r_cnt_sw  <= r_cnt_sw + 16'd1;
      if (nInterC_S_o_brs_icn & nInterC_A_i_brs_icn) r_cnt_icn <= r_cnt_icn + 16'd1;
    end
  end

  assign cnt_sw_o_brs  = r_cnt_sw;
  assign cnt_icn_o_brs = r_cnt_icn;
`endif

endmodule

// File: tb/tb_br_split.sv
// Directed bench for br_split with PE_ID=3: routing, backpressure,
// destination independence, reset flush, and optional delivery counters.
module tb_br_split;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lr_i = 1'b0;
  logic [15:0] node_i = '0;
  logic [11:0] gen_i = '0;
  logic [31:0] opr_i = '0;
  logic        uni_i = 1'b0;
  logic [1:0]  wen_i = '0;
  logic        s_i = 1'b0;
  logic        a_o;
  logic        lr_sw, uni_sw, lr_icn, uni_icn;
  logic [15:0] node_sw, node_icn;
  logic [11:0] gen_sw, gen_icn;
  logic [31:0] opr_sw, opr_icn;
  logic [1:0]  wen_sw, wen_icn;
  logic        s_sw, s_icn;
  logic        a_sw = 1'b0;
  logic        a_icn = 1'b0;
`ifdef BR_SPLIT_STAT_EN
  logic [15:0] cnt_sw, cnt_icn;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  br_split #(.PE_ID(4'h3)) dut (
    .clk(clk), .rst(rst),
`ifdef BR_SPLIT_STAT_EN
    .cnt_sw_o_brs(cnt_sw), .cnt_icn_o_brs(cnt_icn),
`endif
    .lr_i_brs(lr_i), .node_i_brs(node_i), .gen_i_brs(gen_i), .opr_i_brs(opr_i),
    .uni_opr_i_brs(uni_i), .mem_wen_i_brs(wen_i),
    .nInterC_S_i_brs(s_i), .nInterC_A_o_brs(a_o),
    .lr_o_brs_sw(lr_sw), .node_o_brs_sw(node_sw), .gen_o_brs_sw(gen_sw),
    .opr_o_brs_sw(opr_sw), .uni_opr_o_brs_sw(uni_sw), .mem_wen_o_brs_sw(wen_sw),
    .nInterC_S_o_brs_sw(s_sw), .nInterC_A_i_brs_sw(a_sw),
    .lr_o_brs_icn(lr_icn), .node_o_brs_icn(node_icn), .gen_o_brs_icn(gen_icn),
    .opr_o_brs_icn(opr_icn), .uni_opr_o_brs_icn(uni_icn), .mem_wen_o_brs_icn(wen_icn),
    .nInterC_S_o_brs_icn(s_icn), .nInterC_A_i_brs_icn(a_icn)
  );

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic offer(input logic [15:0] node, input logic [1:0] wen, input logic [31:0] opr);
    node_i = node; wen_i = wen; opr_i = opr; s_i = 1'b1;
    lr_i = opr[0]; gen_i = opr[11:0]; uni_i = opr[1];
  endtask

  task automatic test_reset();
    offer(16'h3000, 2'b00, 32'hAAAA_5555);
    #1;
    n_checks++; if (a_o !== 1'b0) begin n_errors++; $display("FAIL rst_ack got %b exp 0", a_o); end
    n_checks++; if ({s_sw, s_icn} !== 2'b00) begin n_errors++; $display("FAIL rst_send got %b exp 00", {s_sw, s_icn}); end
    n_checks++; if ({node_sw, opr_sw, wen_sw, lr_sw} !== '0) begin n_errors++; $display("FAIL rst_sw_data got %h/%h exp 0", node_sw, opr_sw); end
    n_checks++; if ({node_icn, opr_icn, gen_icn, uni_icn} !== '0) begin n_errors++; $display("FAIL rst_icn_data got %h/%h exp 0", node_icn, opr_icn); end
    s_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_route_sw();
    a_sw = 1'b0;
    offer(16'h3A00, 2'b00, 32'h1111_2222);
    #1;
    n_checks++; if (a_o !== 1'b1) begin n_errors++; $display("FAIL sw_ack got %b exp 1", a_o); end
    tick(); s_i = 1'b0;
    n_checks++; if (s_sw !== 1'b1) begin n_errors++; $display("FAIL sw_send got %b exp 1", s_sw); end
    n_checks++; if (node_sw !== 16'h3A00) begin n_errors++; $display("FAIL sw_node got %h exp 3a00", node_sw); end
    n_checks++; if (opr_sw !== 32'h1111_2222 || gen_sw !== 12'h222) begin n_errors++; $display("FAIL sw_opr got %h/%h exp 11112222/222", opr_sw, gen_sw); end
    n_checks++; if (s_icn !== 1'b0) begin n_errors++; $display("FAIL sw_icn_quiet got %b exp 0", s_icn); end
    tick();
    n_checks++; if (s_sw !== 1'b1 || node_sw !== 16'h3A00) begin n_errors++; $display("FAIL sw_hold got %b/%h exp 1/3a00", s_sw, node_sw); end
    a_sw = 1'b1; tick(); a_sw = 1'b0;
    n_checks++; if (s_sw !== 1'b0) begin n_errors++; $display("FAIL sw_drain got %b exp 0", s_sw); end
  endtask

  task automatic test_route_icn();
    a_icn = 1'b1;
    offer(16'h5000, 2'b00, 32'h0000_0ABC);
    tick(); s_i = 1'b0;
    n_checks++; if ({s_icn, s_sw} !== 2'b10) begin n_errors++; $display("FAIL icn_remote got %b exp 10", {s_icn, s_sw}); end
    n_checks++; if (node_icn !== 16'h5000 || opr_icn !== 32'h0000_0ABC) begin n_errors++; $display("FAIL icn_remote_data got %h/%h exp 5000/abc", node_icn, opr_icn); end
    offer(16'h3000, 2'b01, 32'h0000_0DEF);
    tick(); s_i = 1'b0;
    n_checks++; if ({s_icn, s_sw} !== 2'b10) begin n_errors++; $display("FAIL icn_wen got %b exp 10", {s_icn, s_sw}); end
    n_checks++; if (wen_icn !== 2'b01 || node_icn !== 16'h3000) begin n_errors++; $display("FAIL icn_wen_data got %b/%h exp 01/3000", wen_icn, node_icn); end
    tick();
    n_checks++; if (s_icn !== 1'b0) begin n_errors++; $display("FAIL icn_drain got %b exp 0", s_icn); end
    a_icn = 1'b0;
  endtask

  task automatic test_backpressure();
    a_sw = 1'b0;
    offer(16'h3001, 2'b00, 32'd1); #1;
    n_checks++; if (a_o !== 1'b1) begin n_errors++; $display("FAIL bp_ack1 got %b exp 1", a_o); end
    tick();
    offer(16'h3002, 2'b00, 32'd2); #1;
    n_checks++; if (a_o !== 1'b1) begin n_errors++; $display("FAIL bp_ack2 got %b exp 1", a_o); end
    tick();
    offer(16'h3003, 2'b00, 32'd3); #1;
    n_checks++; if (a_o !== 1'b0) begin n_errors++; $display("FAIL bp_ack3_full got %b exp 0", a_o); end
    tick();
    n_checks++; if (a_o !== 1'b0 || s_sw !== 1'b1 || opr_sw !== 32'd1) begin n_errors++; $display("FAIL bp_held got %b/%b/%0d exp 0/1/1", a_o, s_sw, opr_sw); end
    a_sw = 1'b1; #1;
    n_checks++; if (a_o !== 1'b0) begin n_errors++; $display("FAIL bp_full_ignores_ack got %b exp 0", a_o); end
    tick();
    n_checks++; if (opr_sw !== 32'd2 || a_o !== 1'b1) begin n_errors++; $display("FAIL bp_second got %0d/%b exp 2/1", opr_sw, a_o); end
    tick(); s_i = 1'b0;
    n_checks++; if (opr_sw !== 32'd3 || s_sw !== 1'b1) begin n_errors++; $display("FAIL bp_third got %0d/%b exp 3/1", opr_sw, s_sw); end
    tick();
    n_checks++; if (s_sw !== 1'b0) begin n_errors++; $display("FAIL bp_empty got %b exp 0", s_sw); end
    a_sw = 1'b0;
  endtask

  // Leaves both FIFOs full for the reset test that follows.
  task automatic test_independence();
    a_sw = 1'b0; a_icn = 1'b0;
    offer(16'h3004, 2'b00, 32'd4); tick();
    offer(16'h3005, 2'b00, 32'd5); tick();
    offer(16'h7000, 2'b00, 32'd6); #1;
    n_checks++; if (a_o !== 1'b1) begin n_errors++; $display("FAIL ind_ack got %b exp 1", a_o); end
    tick();
    n_checks++; if (s_icn !== 1'b1 || opr_icn !== 32'd6 || s_sw !== 1'b1 || opr_sw !== 32'd4) begin
      n_errors++; $display("FAIL ind_icn got %b/%0d sw %b/%0d exp 1/6 1/4", s_icn, opr_icn, s_sw, opr_sw); end
    offer(16'h7001, 2'b00, 32'd7); tick();
    s_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    a_sw = 1'b1; a_icn = 1'b1;
    offer(16'h3009, 2'b00, 32'd9);
    rst = 1'b1; #1;
    n_checks++; if ({s_sw, s_icn, a_o} !== 3'b000) begin n_errors++; $display("FAIL rstmid_immediate got %b exp 000", {s_sw, s_icn, a_o}); end
    tick();
    n_checks++; if ({s_sw, s_icn} !== 2'b00 || opr_sw !== '0 || opr_icn !== '0) begin n_errors++; $display("FAIL rstmid_flushed got %b %h %h exp 00 0 0", {s_sw, s_icn}, opr_sw, opr_icn); end
    rst = 1'b0;
    offer(16'h3008, 2'b00, 32'd8); #1;
    n_checks++; if (a_o !== 1'b1) begin n_errors++; $display("FAIL rstmid_first_ack got %b exp 1", a_o); end
    tick(); s_i = 1'b0;
    n_checks++; if (s_sw !== 1'b1 || opr_sw !== 32'd8 || s_icn !== 1'b0) begin n_errors++; $display("FAIL rstmid_first got %b/%0d icn %b exp 1/8 0", s_sw, opr_sw, s_icn); end
    tick();
    n_checks++; if ({s_sw, s_icn} !== 2'b00) begin n_errors++; $display("FAIL rstmid_no_stale got %b exp 00", {s_sw, s_icn}); end
    a_sw = 1'b0; a_icn = 1'b0;
  endtask

`ifdef BR_SPLIT_STAT_EN
  task automatic test_stat();
    rst = 1'b1; #1;
    n_checks++; if (cnt_sw !== 16'd0 || cnt_icn !== 16'd0) begin n_errors++; $display("FAIL stat_reset got %0d/%0d exp 0/0", cnt_sw, cnt_icn); end
    tick(); rst = 1'b0;
    a_sw = 1'b1; a_icn = 1'b1;
    offer(16'h6000, 2'b00, 32'd1); tick(); s_i = 1'b0; tick();
    n_checks++; if (cnt_icn !== 16'd1 || cnt_sw !== 16'd0) begin n_errors++; $display("FAIL stat_icn_one got %0d/%0d exp 1/0", cnt_icn, cnt_sw); end
    offer(16'h3000, 2'b00, 32'd2);
    for (int i = 0; i < 65535; i++) tick();
    s_i = 1'b0; tick();
    n_checks++; if (cnt_sw !== 16'hFFFF || cnt_icn !== 16'd1) begin n_errors++; $display("FAIL stat_preload got %h/%0d exp ffff/1", cnt_sw, cnt_icn); end
    offer(16'h3000, 2'b00, 32'd3); tick(); s_i = 1'b0; tick();
    n_checks++; if (cnt_sw !== 16'd0 || cnt_icn !== 16'd1) begin n_errors++; $display("FAIL stat_wrap got %h/%0d exp 0/1", cnt_sw, cnt_icn); end
  endtask
`endif

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_route_sw();
    test_route_icn();
    test_backpressure();
    test_independence();
    test_reset_mid();
`ifdef BR_SPLIT_STAT_EN
    test_stat();
`endif
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/br_split.md
BR_SPLIT -- requirements
Module: br_split

Interface
REQ-001 Parameter PE_ID, default 4'h0: local processing-element number used for routing.
REQ-002 Port clk, input, 1: single clock; all state on rising edge.
REQ-003 Port rst, input, 1: asynchronous, active-high reset.
REQ-004 Ports lr_i_brs/node_i_brs/gen_i_brs/opr_i_brs/uni_opr_i_brs/mem_wen_i_brs, input, 1/16/12/32/1/2: incoming packet fields, 64 bits total.
REQ-005 Port nInterC_S_i_brs, input, 1: upstream send (packet valid).
REQ-006 Port nInterC_A_o_brs, output, 1: ack to upstream (packet accepted).
REQ-007 Ports *_o_brs_sw, output, same widths as REQ-004: packet to the local switch path.
REQ-008 Ports nInterC_S_o_brs_sw (output, 1) and nInterC_A_i_brs_sw (input, 1): switch-path send and ack.
REQ-009 Ports *_o_brs_icn, output, same widths as REQ-004: packet to the ICN path.
REQ-010 Ports nInterC_S_o_brs_icn (output, 1) and nInterC_A_i_brs_icn (input, 1): ICN-path send and ack.

Function
REQ-011 Transfer on any port SHALL occur on a rising edge where send and ack are both high.
REQ-012 Route SHALL be ICN if mem_wen_i_brs != 2'b00 or node_i_brs[15:12] != PE_ID; otherwise Sw.
REQ-013 Each destination SHALL own a 2-entry FIFO holding the full 64-bit packet.
REQ-014 nInterC_A_o_brs SHALL equal "not full" of the FIFO selected by REQ-012. It is combinational from the input fields and the registered full flag only, never from downstream acks.
REQ-015 Latency SHALL be 1 cycle: a packet accepted at edge N is presented with send high after edge N.
REQ-016 Output send SHALL equal "FIFO not empty"; data outputs SHALL show the FIFO head and stay stable until the transfer.
REQ-017 A full FIFO SHALL refuse writes even when a read occurs in the same cycle; simultaneous read and write on a non-full FIFO SHALL both take effect.
REQ-018 Order SHALL be preserved within each destination; no ordering guarantee exists between destinations.
REQ-019 A stalled destination SHALL NOT block packets routed to the other destination, except for the packet currently at the input.
REQ-020 FIFO pointers SHALL wrap modulo 2; occupancy SHALL be a 2-bit count from 0 to 2.

Reset
REQ-021 While rst is high: both FIFOs empty, all send outputs 0, all data outputs 0, nInterC_A_o_brs 0.
REQ-022 Asserting reset mid-transfer SHALL discard all buffered packets; no partial packet is emitted after release.
REQ-023 The first acceptance SHALL be possible on the first rising edge after rst deasserts.

Configuration
REQ-024 Macro BR_SPLIT_STAT_EN defined: adds output ports cnt_sw_o_brs[15:0] and cnt_icn_o_brs[15:0].
REQ-025 Each counter SHALL count delivered packets on its destination, wrap 16'hFFFF->0, and reset to 0.
REQ-026 Macro undefined: the counter ports and logic SHALL be absent; all other behaviour is identical.

Structure
REQ-027 Package br_pkg SHALL hold the field widths, PKT_W = 64, FIFO depth 2, and the packet pack/unpack field offsets.
REQ-028 Sub-module br_fifo2 (2-entry, 64-bit, with full/empty flags) SHALL be instantiated once per destination.

Verification
REQ-029 PE_ID=3, node=16'h3A00, mem_wen=0, send for 1 cycle -> Sw send high next cycle with node 16'h3A00; ICN send stays 0.
REQ-030 node=16'h5000 (or mem_wen=2'b01 with node=16'h3000) -> packet appears on ICN only.
REQ-031 Sw ack held 0, three Sw-routed packets offered -> two accepted, third held with nInterC_A_o_brs=0; release ack -> all three delivered in order.
REQ-032 Sw full and stalled, ICN-routed packet offered -> accepted and delivered on ICN next cycle.
REQ-033 Assert rst with both FIFOs holding 2 entries -> all sends 0 immediately; after release, no stale packet is emitted.
REQ-034 With BR_SPLIT_STAT_EN, cnt_sw preloaded by 65535 deliveries, then one more -> cnt_sw_o_brs=0; cnt_icn unchanged.
